// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and the rotating priority search
// for the 8-way round-robin arbiter.
package rr_arbiter8_pkg;

   localparam int unsigned N_REQ = 8;
   localparam int unsigned IDX_W = 3;

   // Two-state FSM, kept as plain constants for legacy tools.
   typedef logic [0:0] state_t;
   localparam state_t IDLE  = 1'b0;
   localparam state_t GRANT = 1'b1;

   // Returns {found, index} of the first set request at ptr, ptr+1, ... modulo N_REQ.
   // The loop scans downward so the smallest offset from ptr is written last and wins.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] ptr);
      logic             found;
      logic [IDX_W-1:0] idx;
      logic [IDX_W-1:0] cand;
      found = 1'b0;
      idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         cand = ptr + IDX_W'(i);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
      return {found, idx};
   endfunction

endpackage

// File: rtl/rr_arbiter8_decoder3to8.sv
// Existing 3-to-8 binary-to-one-hot decoder used to form the grant vector.
module decoder3to8 (
   input  logic [2:0] sel,
   output logic [7:0] onehot
);

   always_comb begin
      onehot = 8'b0000_0001 << sel;
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with a per-grant hold limit.
// One idle cycle always separates consecutive grants.
module rr_arbiter8
   import rr_arbiter8_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid,
   output logic             timeout
);

   localparam logic [4:0] HOLD_LAST = 5'(MAX_HOLD - 1);

   state_t           state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [IDX_W-1:0] idx_q;
   logic [4:0]       hold_cnt_q;
   logic             timeout_q;

   logic [IDX_W:0]   pick;
   logic             hold_hit;
   logic             req_drop;
   logic             release_now;
   logic [N_REQ-1:0] dec_onehot;

   always_comb begin
      pick        = rr_pick(req, ptr_q);
      hold_hit    = (hold_cnt_q == HOLD_LAST);
      req_drop    = ~req[idx_q];
      release_now = (state_q == GRANT) && (done || req_drop || hold_hit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         ptr_q      <= '0;
         idx_q      <= '0;
         hold_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               timeout_q <= 1'b0;
               if (pick[IDX_W]) begin
                  idx_q      <= pick[IDX_W-1:0];
                  hold_cnt_q <= '0;
                  state_q    <= GRANT;
               end
            end
            GRANT: begin
               if (release_now) begin
                  state_q   <= IDLE;
                  ptr_q     <= idx_q + 3'd1;
                  // Pulse only when the hold limit alone forced the release.
                  timeout_q <= hold_hit && !done && !req_drop;
               end else begin
                  timeout_q <= 1'b0;
                  if (hold_cnt_q != 5'h1f) begin
                     hold_cnt_q <= hold_cnt_q + 5'd1;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               timeout_q <= 1'b0;
            end
         endcase
      end
   end

   decoder3to8 u_decoder (
      .sel    (idx_q),
      .onehot (dec_onehot)
   );

   always_comb begin
      grant_valid = (state_q == GRANT);
      grant_idx   = idx_q;
      grant       = dec_onehot & {N_REQ{grant_valid}};
      timeout     = timeout_q;
   end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: expected outputs are queued as each cycle is
// driven, then popped and checked just after the clock edge.
module tb_rr_arbiter8;

   typedef struct {
      logic [7:0] grant;
      logic       tmo;
      string      tag;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] grant;
   logic [2:0] grant_idx;
   logic       grant_valid;
   logic       timeout;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   rr_arbiter8 #(.MAX_HOLD(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .done        (done),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] idx_of(input logic [7:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) r = 3'(i);
      end
      return r;
   endfunction

   // Drive one cycle, queue what must be visible after the edge, then check it.
   task automatic cyc(input string tag, input logic r, input logic [7:0] rq, input logic d,
                      input logic [7:0] eg, input logic et);
      exp_t e;
      exp_t got;
      rst  = r;
      req  = rq;
      done = d;
      e.grant = eg;
      e.tmo   = et;
      e.tag   = tag;
      sb.push_back(e);
      @(posedge clk);
      #1;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s: scoreboard empty, observed grant %h", tag, grant);
      end
      if (sb.size() > 0) begin
         got = sb.pop_front();
         checks++;
         assert (grant === got.grant) else begin
            errors++;
            $error("FAIL %s grant: observed %h expected %h", got.tag, grant, got.grant);
         end
         checks++;
         assert (grant_valid === (got.grant != 8'h00)) else begin
            errors++;
            $error("FAIL %s grant_valid: observed %b expected %b", got.tag, grant_valid,
                   (got.grant != 8'h00));
         end
         checks++;
         assert (timeout === got.tmo) else begin
            errors++;
            $error("FAIL %s timeout: observed %b expected %b", got.tag, timeout, got.tmo);
         end
         if (got.grant != 8'h00) begin
            checks++;
            assert (grant_idx === idx_of(got.grant)) else begin
               errors++;
               $error("FAIL %s grant_idx: observed %0d expected %0d", got.tag, grant_idx,
                      idx_of(got.grant));
            end
         end
      end
   endtask

   initial begin
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;

      // Reset, then idle with no requests; done in IDLE must be ignored.
      cyc("reset", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      cyc("reset", 1'b1, 8'h00, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < 5; i++) cyc("idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      cyc("idle_done", 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);

      // Rotation through all requesters and back to 0; ends with ptr=1.
      for (int k = 0; k < 9; k++) begin
         cyc("rot_grant", 1'b0, 8'hFF, 1'b0, 8'(1 << (k % 8)), 1'b0);
         cyc("rot_idle", 1'b0, 8'hFF, 1'b1, 8'h00, 1'b0);
      end

      // Wrap-around: grant/release requester 2 (ptr=3), then req=05 picks index 0.
      cyc("wrap_g2", 1'b0, 8'h04, 1'b0, 8'h04, 1'b0);
      cyc("wrap_rel2", 1'b0, 8'h04, 1'b1, 8'h00, 1'b0);
      cyc("wrap_g0", 1'b0, 8'h05, 1'b0, 8'h01, 1'b0);
      cyc("wrap_rel0", 1'b0, 8'h05, 1'b1, 8'h00, 1'b0);
      cyc("wrap_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // Timeout: exactly 16 grant cycles, one-cycle pulse, then regranted.
      for (int i = 0; i < 16; i++) cyc("tmo_hold", 1'b0, 8'h08, 1'b0, 8'h08, 1'b0);
      cyc("tmo_pulse", 1'b0, 8'h08, 1'b0, 8'h00, 1'b1);
      cyc("tmo_regrant", 1'b0, 8'h08, 1'b0, 8'h08, 1'b0);
      cyc("tmo_rel", 1'b0, 8'h08, 1'b1, 8'h00, 1'b0);
      cyc("tmo_idle", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // Request drop: ptr=4, req=06 grants 1; dropping bit 1 releases with no timeout.
      cyc("drop_g1", 1'b0, 8'h06, 1'b0, 8'h02, 1'b0);
      cyc("drop_hold", 1'b0, 8'h06, 1'b0, 8'h02, 1'b0);
      cyc("drop_rel", 1'b0, 8'h04, 1'b0, 8'h00, 1'b0);
      cyc("drop_g2", 1'b0, 8'h04, 1'b0, 8'h04, 1'b0);
      cyc("drop_done", 1'b0, 8'h04, 1'b1, 8'h00, 1'b0);

      // Mid-grant reset: ptr=3 so req=20 grants 5; reset drops it and ptr returns to 0.
      cyc("rst_g5", 1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
      cyc("rst_hold", 1'b0, 8'h20, 1'b0, 8'h20, 1'b0);
      cyc("rst_mid", 1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
      cyc("rst_resume", 1'b0, 8'h30, 1'b0, 8'h10, 1'b0);
      cyc("rst_rel", 1'b0, 8'h30, 1'b1, 8'h00, 1'b0);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain: observed %0d entries expected 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
